// File: rtl/password_scanner.sv
// BCD password range scanner: counts six-digit candidates with non-decreasing digits and an adjacent pair.
// Optional build macro PASSWORD_STRICT_PAIR_EN restricts the pair rule to runs of exactly two digits.
module password_scanner #(
    parameter int COUNT_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [23:0]        range_lo,
    input  logic [23:0]        range_hi,
    output logic               busy,
    output logic               done,
    output logic               input_err,
    output logic [COUNT_W-1:0] count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t      state, state_nx;
    logic [23:0] cand;
    logic        valid_q, match_q;
    logic        load, bad_digit, lo_gt_hi, cand_last, cand_match, pair;
    logic [4:0]  eq, le;

    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (range_lo[4*i +: 4] > 4'd9 || range_hi[4*i +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    // With all digits valid, BCD ordering matches plain binary ordering.
    assign lo_gt_hi  = range_lo > range_hi;
    assign cand_last = cand == range_hi;

    // eq[i]/le[i] relate digit i to its more significant neighbour i+1.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            eq[i] = cand[4*i +: 4] == cand[4*(i+1) +: 4];
            le[i] = cand[4*(i+1) +: 4] <= cand[4*i +: 4];
        end
    end

`ifdef PASSWORD_STRICT_PAIR_EN
    // A pair qualifies only when neither neighbouring pair is also equal.
    assign pair = |(eq & ~{eq[3:0], 1'b0} & ~{1'b0, eq[4:1]});
`else
    assign pair = |eq;
`endif

    assign cand_match = (&le) & pair;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load = 1'b1;
                    if (bad_digit || lo_gt_hi) state_nx = DONE;
                    else                       state_nx = SCAN;
                end
            end
            SCAN:    if (cand_last) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand      <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            count     <= '0;
            input_err <= 1'b0;
        end else begin
            if (valid_q && match_q && count != {COUNT_W{1'b1}})
                count <= count + COUNT_W'(1);
            valid_q <= 1'b0;
            if (state == SCAN) begin
                valid_q <= 1'b1;
                match_q <= cand_match;
                if (!cand_last) cand <= bcd_inc(cand);
            end
            if (load) begin
                count     <= '0;
                input_err <= bad_digit;
                cand      <= range_lo;
                valid_q   <= 1'b0;
            end
        end
    end

    assign busy = (state == SCAN) || (state == DRAIN);
    assign done = state == DONE;

endmodule
